// File: rtl/dds_dac_pkg.sv
// Shared types and constants for the DDS DAC SPI output stage.
// Frame = 8 control bits + 16 data bits, MSB first.
package dds_dac_pkg;

  localparam int         DAC_DATA_BITS   = 16;
  localparam int         DAC_CTRL_BITS   = 8;
  localparam int         DAC_FRAME_BITS  = 24;
  localparam logic [7:0] DAC_CTRL_NORMAL = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } dac_state_e;

endpackage

// File: rtl/dds_dac_spi_out_if.sv
// Sample handshake plus SPI DAC pins for dds_dac_spi_out.
// master: sample source side; slave: the serialiser.
interface dds_dac_spi_out_if
  import dds_dac_pkg::*;
  ();

  logic [DAC_DATA_BITS-1:0] sample_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic                     dac_sclk;
  logic                     dac_sync_n;
  logic                     dac_din;
  logic                     busy;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  dac_sclk,
    input  dac_sync_n,
    input  dac_din,
    input  busy
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output dac_sclk,
    output dac_sync_n,
    output dac_din,
    output busy
  );

endinterface

// File: rtl/dac_bit_timer.sv
// SCLK half-period timer: counts CLK_DIV cycles while en is high.
// Ports: clk, rst_n, en, clr (restart), half_done (1-cycle pulse).
module dac_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic half_done
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign half_done = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || half_done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dds_dac_spi_out.sv
// Serialises 16-bit samples into 24-bit SPI DAC frames (ctrl + data).
// Ports: clk, reset (async, active-low), dac (slave: handshake + SPI pins).
// Build option DAC_OFFSET_BINARY_EN: send data as offset binary.
module dds_dac_spi_out
  import dds_dac_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         FRAME_BITS = DAC_FRAME_BITS,
  parameter logic [7:0] CTRL_WORD  = DAC_CTRL_NORMAL
) (
  input  logic               clk,
  input  logic               reset,
  dds_dac_spi_out_if.slave   dac
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  dac_state_e               state;
  dac_state_e               state_nx;
  logic [FRAME_BITS-1:0]    sreg;
  logic [4:0]               bit_cnt;
  logic [DAC_DATA_BITS-1:0] data;
  logic                     accept;
  logic                     half_done;
  logic                     last_bit;

  assign accept   = (state == IDLE) && dac.sample_valid;
  assign last_bit = (bit_cnt == LAST_BIT);

`ifdef DAC_OFFSET_BINARY_EN
  assign data = {~dac.sample_in[15], dac.sample_in[14:0]};
`else
  assign data = dac.sample_in;
`endif

  dac_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .en        (state != IDLE),
    .clr       (accept),
    .half_done (half_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept)    state_nx = SHIFT_HI;
      SHIFT_HI: if (half_done) state_nx = SHIFT_LO;
      SHIFT_LO: if (half_done) state_nx = last_bit ? HOLD : SHIFT_HI;
      HOLD:     if (half_done) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Shift only on the SHIFT_LO -> SHIFT_HI turn so dac_din is
  // stable across each falling SCLK edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sreg    <= FRAME_BITS'({CTRL_WORD, data});
      bit_cnt <= '0;
    end else if (state == SHIFT_LO && half_done && !last_bit) begin
      sreg    <= sreg << 1;
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_comb begin
    dac.sample_ready = 1'b0;
    dac.busy         = 1'b1;
    dac.dac_sclk     = 1'b1;
    dac.dac_sync_n   = 1'b0;
    dac.dac_din      = sreg[FRAME_BITS-1];
    unique case (state)
      IDLE: begin
        dac.sample_ready = 1'b1;
        dac.busy         = 1'b0;
        dac.dac_sync_n   = 1'b1;
        dac.dac_din      = 1'b0;
      end
      SHIFT_HI: ;
      SHIFT_LO: dac.dac_sclk = 1'b0;
      HOLD: begin
        dac.dac_sync_n = 1'b1;
        dac.dac_din    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
